// File: rtl/apb_master_bridge_if.sv
// Request/response port and APB bus of the peripheral bridge, bundled as one interface.
// The master modport is the bridge's view; the slave modport is the CPU side plus the APB slaves.
interface apb_master_bridge_if #(
  parameter int unsigned NUM_SLV = 4
) ();

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [31:0]            req_addr;
  logic [31:0]            req_wdata;

  logic                   rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;

  logic [31:0]            PADDR;
  logic                   PWRITE;
  logic                   PENABLE;
  logic [31:0]            PWDATA;
  logic [NUM_SLV-1:0]     PSEL;
  logic [NUM_SLV*32-1:0]  PRDATA;
  logic [NUM_SLV-1:0]     PREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: decodes a request to one of NUM_SLV slaves, runs
// SETUP/ACCESS with a bounded wait-state timeout and returns a one-cycle response strobe.
module apb_master_bridge #(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_master_bridge_if.master io_bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_req_ready, w_req_ready_next;
  logic               r_rsp_valid, w_rsp_valid_next;
  logic [31:0]        r_rsp_rdata, w_rsp_rdata_next;
  logic               r_rsp_err,   w_rsp_err_next;
  logic [NUM_SLV-1:0] r_psel,      w_psel_next;
  logic               r_penable,   w_penable_next;
  logic               r_pwrite,    w_pwrite_next;
  logic [31:0]        r_paddr,     w_paddr_next;
  logic [31:0]        r_pwdata,    w_pwdata_next;
  logic [7:0]         r_cnt,       w_cnt_next;

  logic [3:0]         w_idx;
  logic [NUM_SLV-1:0] w_onehot;
  logic               w_hit;
  logic               w_accept;
  logic               w_pready;
  logic               w_timeout;
  logic [31:0]        w_prdata;
  logic [31:0]        w_prdata_slice [NUM_SLV];

  assign w_idx = io_bus.req_addr[15:12];

  // The latched one-hot select doubles as the slave index for the read-data/ready mux.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
      assign w_onehot[gi]       = ({28'd0, w_idx} == 32'(gi));
      assign w_prdata_slice[gi] = io_bus.PRDATA[32*gi +: 32] & {32{r_psel[gi]}};
    end
  endgenerate

  always_comb begin
    w_prdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      w_prdata = w_prdata | w_prdata_slice[i];
    end
  end

  assign w_pready  = |(io_bus.PREADY & r_psel);
  assign w_hit     = (io_bus.req_addr[31:16] == BASE_ADDR[31:16]) && (|w_onehot);
  assign w_accept  = (r_state == S_IDLE) && io_bus.req_valid;
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_req_ready <= w_req_ready_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_err   <= w_rsp_err_next;
      r_psel      <= w_psel_next;
      r_penable   <= w_penable_next;
      r_pwrite    <= w_pwrite_next;
      r_paddr     <= w_paddr_next;
      r_pwdata    <= w_pwdata_next;
      r_cnt       <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (io_bus.req_valid) w_state_next = w_hit ? S_SETUP : S_RESP;
      S_SETUP:  w_state_next = S_ACCESS;
      S_ACCESS: if (w_pready || w_timeout) w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Every output is a register; this process computes their next values.
  always_comb begin
    w_req_ready_next = (w_state_next == S_IDLE);
    w_rsp_valid_next = 1'b0;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_err_next   = r_rsp_err;
    w_psel_next      = r_psel;
    w_penable_next   = r_penable;
    w_pwrite_next    = r_pwrite;
    w_paddr_next     = r_paddr;
    w_pwdata_next    = r_pwdata;
    w_cnt_next       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_hit) begin
          w_psel_next    = w_onehot;
          w_penable_next = 1'b0;
          w_pwrite_next  = io_bus.req_write;
          w_paddr_next   = io_bus.req_addr;
          w_pwdata_next  = io_bus.req_wdata;
        end else if (w_accept) begin
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = '0;
          w_rsp_err_next   = 1'b1;
        end
      end
      S_SETUP: begin
        w_penable_next = 1'b1;
      end
      S_ACCESS: begin
        w_cnt_next = r_cnt + 8'd1;
        // A ready slave wins over the timeout in the same cycle.
        if (w_pready || w_timeout) begin
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = !w_pready;
          w_rsp_rdata_next = (w_pready && !r_pwrite) ? w_prdata : 32'd0;
          w_psel_next      = '0;
          w_penable_next   = 1'b0;
        end
      end
      S_RESP: begin
        w_cnt_next = '0;
      end
      default: begin
        w_psel_next    = '0;
        w_penable_next = 1'b0;
        w_cnt_next     = '0;
      end
    endcase
  end

  assign io_bus.req_ready = r_req_ready;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_rdata = r_rsp_rdata;
  assign io_bus.rsp_err   = r_rsp_err;
  assign io_bus.PSEL      = r_psel;
  assign io_bus.PENABLE   = r_penable;
  assign io_bus.PWRITE    = r_pwrite;
  assign io_bus.PADDR     = r_paddr;
  assign io_bus.PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, hand-written corner
// sequences and randomized requests checked against a transaction-level reference model.
module tb_apb_master_bridge;

  localparam int NUM_SLV = 4;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 255;
  localparam int NVEC    = 9;

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  apb_master_bridge_if #(.NUM_SLV(NUM_SLV)) bus ();

  apb_master_bridge #(
    .NUM_SLV  (NUM_SLV),
    .BASE_ADDR(32'h1000_0000),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .io_bus(bus)
  );

  // Slave models: slave i raises PREADY once it has seen slv_lat[i] ACCESS cycles.
  int                 slv_lat  [NUM_SLV];
  logic [31:0]        slv_data [NUM_SLV];
  int                 acc_cnt  [NUM_SLV];
  logic [NUM_SLV-1:0] force_rdy;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_SLV; i++) acc_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < NUM_SLV; i++)
        acc_cnt[i] <= (bus.PSEL[i] && bus.PENABLE) ? acc_cnt[i] + 1 : 0;
    end
  end

  always_comb begin
    bus.PREADY = force_rdy;
    bus.PRDATA = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (bus.PSEL[i] && bus.PENABLE && (acc_cnt[i] >= slv_lat[i])) bus.PREADY[i] = 1'b1;
      bus.PRDATA[32*i +: 32] = slv_data[i];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome and timing from decode result and slave wait states.
  function automatic void ref_model(input logic [31:0] addr, input bit wr, input int lat,
                                    input logic [31:0] sdata, output bit err,
                                    output logic [31:0] rd, output int rsp_lat,
                                    output int n_setup, output int n_access);
    bit hit;
    hit = (addr[31:16] == 16'h1000) && (int'(addr[15:12]) < NUM_SLV);
    if (!hit) begin
      err = 1'b1; rd = 32'd0; rsp_lat = 1; n_setup = 0; n_access = 0;
    end else if (lat < TIMEOUT) begin
      err = 1'b0; rd = wr ? 32'd0 : sdata; rsp_lat = 3 + lat; n_setup = 1; n_access = lat + 1;
    end else begin
      err = 1'b1; rd = 32'd0; rsp_lat = 2 + TIMEOUT; n_setup = 1; n_access = TIMEOUT;
    end
  endfunction

  logic [31:0] exp_hold_rdata = 32'd0;
  logic        exp_hold_err   = 1'b0;
  logic [31:0] exp_hold_paddr = 32'd0;
  bit          exp_paddr_known = 1'b1;

  task automatic exec(input string tag, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit hold, input bit stale,
                      input bit e_err, input logic [31:0] e_rdata, input int e_lat,
                      input int e_setup, input int e_access);
    int wait_cyc = 0;
    int lat = 0;
    int n_setup = 0;
    int n_access = 0;
    bit hs = 1'b0;
    bit got = 1'b0;
    bit bus_ok = 1'b1;
    bit busy_ok = 1'b1;
    bit idle_ok = 1'b1;
    logic [31:0] rdata = 32'd0;
    logic err = 1'b0;
    logic [NUM_SLV-1:0] one = 1;
    logic [NUM_SLV-1:0] exp_oh;
    exp_oh = (e_setup != 0) ? (one << addr[15:12]) : '0;

    for (int c = 0; c < 40 && !hs; c++) begin
      @(posedge PCLK); #1;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      @(negedge PCLK);
      if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== exp_hold_rdata ||
          bus.rsp_err !== exp_hold_err || bus.PSEL !== '0 || bus.PENABLE !== 1'b0) idle_ok = 1'b0;
      if (exp_paddr_known && bus.PADDR !== exp_hold_paddr) idle_ok = 1'b0;
      if (bus.req_ready === 1'b1) hs = 1'b1;
      else wait_cyc++;
    end

    @(posedge PCLK); #1;
    if (!hold) bus.req_valid = 1'b0;
    if (stale) force_rdy = exp_oh;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge PCLK);
      if (bus.req_ready !== 1'b0) busy_ok = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        got   = 1'b1;
        lat   = k;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        if (bus.PSEL !== '0 || bus.PENABLE !== 1'b0) bus_ok = 1'b0;
      end else begin
        if (bus.PSEL !== '0) begin
          if (bus.PSEL !== exp_oh || bus.PADDR !== addr || bus.PWRITE !== wr ||
              bus.PWDATA !== wdata) bus_ok = 1'b0;
          if (bus.PENABLE === 1'b1) n_access++;
          else begin
            n_setup++;
            if (n_access != 0) bus_ok = 1'b0;
          end
        end else if (bus.PENABLE !== 1'b0) begin
          bus_ok = 1'b0;
        end
        @(posedge PCLK); #1;
        force_rdy = '0;
      end
    end
    force_rdy = '0;

    check($sformatf("%s_handshake", tag), 32'(hs), 32'd1);
    check($sformatf("%s_wait", tag), wait_cyc, 0);
    check($sformatf("%s_idle", tag), 32'(idle_ok), 32'd1);
    check($sformatf("%s_rsp_seen", tag), 32'(got), 32'd1);
    check($sformatf("%s_latency", tag), lat, e_lat);
    check($sformatf("%s_err", tag), 32'(err), 32'(e_err));
    check($sformatf("%s_rdata", tag), rdata, e_rdata);
    check($sformatf("%s_setup_cycles", tag), n_setup, e_setup);
    check($sformatf("%s_access_cycles", tag), n_access, e_access);
    check($sformatf("%s_bus", tag), 32'(bus_ok), 32'd1);
    check($sformatf("%s_ready_low", tag), 32'(busy_ok), 32'd1);

    exp_hold_rdata = e_rdata;
    exp_hold_err   = e_err;
    if (e_setup != 0) begin
      exp_hold_paddr  = addr;
      exp_paddr_known = 1'b1;
    end else begin
      exp_paddr_known = 1'b0;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          slave;
    int          lat;
    logic [31:0] sdata;
    bit          e_err;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_setup;
    int          e_access;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          rnd_wr;
    int          rnd_kind;
    int          rnd_sl;
    int          rnd_lat;
    logic [31:0] rnd_addr;
    logic [31:0] rnd_wdata;
    bit          m_err;
    logic [31:0] m_rd;
    int          m_lat;
    int          m_setup;
    int          m_access;
    bit          rsp_seen;
    bit          ready_ok;

    //          wr  addr           wdata          sl lat    sdata          err rdata          lat set acc
    vecs[0] = '{1'b1, 32'h1000_0000, 32'h0000_00FF, 0, 1,     32'h1234_5678, 1'b0, 32'h0000_0000, 4,  1, 2};
    vecs[1] = '{1'b0, 32'h1000_2008, 32'h0000_0000, 2, 0,     32'h0000_00A5, 1'b0, 32'h0000_00A5, 3,  1, 1};
    vecs[2] = '{1'b0, 32'h2000_0000, 32'h0000_0000, 0, 0,     32'h1111_1111, 1'b1, 32'h0000_0000, 1,  0, 0};
    vecs[3] = '{1'b0, 32'h1000_7000, 32'h0000_0000, 0, 0,     32'h2222_2222, 1'b1, 32'h0000_0000, 1,  0, 0};
    vecs[4] = '{1'b0, 32'h1000_1010, 32'h0000_0000, 1, NEVER, 32'h5555_5555, 1'b1, 32'h0000_0000, 18, 1, 16};
    vecs[5] = '{1'b0, 32'h1000_3FFC, 32'h0000_0000, 3, 3,     32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 6,  1, 4};
    vecs[6] = '{1'b0, 32'h1000_1000, 32'h0000_0000, 1, 15,    32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 18, 1, 16};
    vecs[7] = '{1'b1, 32'h1000_1004, 32'h1357_9BDF, 1, 16,    32'h0BAD_0BAD, 1'b1, 32'h0000_0000, 18, 1, 16};
    vecs[8] = '{1'b1, 32'h1001_0000, 32'hFFFF_0000, 0, 0,     32'h3333_3333, 1'b1, 32'h0000_0000, 1,  0, 0};

    PRESET        = 1'b1;
    force_rdy     = '0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    for (int i = 0; i < NUM_SLV; i++) begin
      slv_lat[i]  = 0;
      slv_data[i] = 32'd0;
    end

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset_psel", 32'(bus.PSEL), 32'd0);
    check("reset_penable", 32'(bus.PENABLE), 32'd0);
    check("reset_pwrite", 32'(bus.PWRITE), 32'd0);
    check("reset_paddr", bus.PADDR, 32'd0);
    check("reset_pwdata", bus.PWDATA, 32'd0);
    #2 PRESET = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      for (int i = 0; i < NUM_SLV; i++) begin
        slv_data[i] = $urandom;
        slv_lat[i]  = 0;
      end
      slv_lat[vecs[v].slave]  = vecs[v].lat;
      slv_data[vecs[v].slave] = vecs[v].sdata;
      exec($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].wdata, 1'b0, 1'b0,
           vecs[v].e_err, vecs[v].e_rdata, vecs[v].e_lat, vecs[v].e_setup, vecs[v].e_access);
    end

    // req_valid held high across two requests; the second sees a stale PREADY in SETUP.
    for (int i = 0; i < NUM_SLV; i++) slv_data[i] = $urandom;
    slv_lat[0]  = 0;
    slv_lat[2]  = 1;
    slv_data[0] = 32'hA0A0_0001;
    slv_data[2] = 32'hB0B0_0002;
    exec("b2b_first", 1'b0, 32'h1000_0004, 32'h0, 1'b1, 1'b0, 1'b0, 32'hA0A0_0001, 3, 1, 1);
    exec("b2b_second", 1'b0, 32'h1000_2000, 32'h0, 1'b0, 1'b1, 1'b0, 32'hB0B0_0002, 4, 1, 2);

    // Reset asserted while a transfer sits in ACCESS.
    slv_lat[1] = NEVER;
    @(posedge PCLK); #1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h1000_1000;
    bus.req_wdata = 32'h0;
    @(negedge PCLK);
    check("rst_pre_ready", 32'(bus.req_ready), 32'd1);
    @(posedge PCLK); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pre_penable", 32'(bus.PENABLE), 32'd1);
    check("rst_pre_psel", 32'(bus.PSEL), 32'h2);
    #2 PRESET = 1'b1;
    #1;
    check("rst_async_psel", 32'(bus.PSEL), 32'd0);
    check("rst_async_penable", 32'(bus.PENABLE), 32'd0);
    @(posedge PCLK);
    @(negedge PCLK);
    #1 PRESET = 1'b0;
    rsp_seen = 1'b0;
    ready_ok = 1'b1;
    repeat (6) begin
      @(negedge PCLK);
      if (bus.rsp_valid !== 1'b0) rsp_seen = 1'b1;
      if (bus.req_ready !== 1'b1) ready_ok = 1'b0;
    end
    check("rst_no_rsp", 32'(rsp_seen), 32'd0);
    check("rst_ready_after", 32'(ready_ok), 32'd1);
    check("rst_rdata_cleared", bus.rsp_rdata, 32'd0);
    exp_hold_rdata  = 32'd0;
    exp_hold_err    = 1'b0;
    exp_hold_paddr  = 32'd0;
    exp_paddr_known = 1'b1;

    for (int t = 0; t < 40; t++) begin
      rnd_wr    = 1'($urandom_range(0, 1));
      rnd_kind  = $urandom_range(0, 9);
      rnd_sl    = $urandom_range(0, NUM_SLV - 1);
      rnd_wdata = $urandom;
      rnd_lat   = $urandom_range(0, 4);
      for (int i = 0; i < NUM_SLV; i++) begin
        slv_data[i] = $urandom;
        slv_lat[i]  = 0;
      end
      if (rnd_kind == 0) begin
        rnd_addr = $urandom;
        if (rnd_addr[31:16] == 16'h1000) rnd_addr[31] = 1'b1;
      end else if (rnd_kind == 1) begin
        rnd_addr = {16'h1000, 4'($urandom_range(NUM_SLV, 15)), 12'($urandom)};
      end else begin
        rnd_addr = {16'h1000, 4'(rnd_sl), 12'($urandom)};
        if (rnd_kind == 9) rnd_lat = $urandom_range(10, 20);
      end
      slv_lat[rnd_sl] = rnd_lat;
      ref_model(rnd_addr, rnd_wr, rnd_lat, slv_data[rnd_sl], m_err, m_rd, m_lat, m_setup, m_access);
      exec($sformatf("rnd%0d", t), rnd_wr, rnd_addr, rnd_wdata, 1'b0, 1'b0,
           m_err, m_rd, m_lat, m_setup, m_access);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
